// File: rtl/ysyx_25040111_icache_axi_rd_pkg.sv
// Shared AXI4 constants and the read-bridge FSM encoding.
package ysyx_25040111_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_25040111_icache_axi_rd_if.sv
// AXI4 read-only channel bundle (AR + R) between the refill bridge and the interconnect.
interface ysyx_25040111_icache_axi_rd_if #(
  parameter int ID_W = 4
);
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata_i;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata_i, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata_i, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_25040111_icache_axi_rd.sv
// Icache refill bridge: one rstart request becomes one AXI4 AR burst; each accepted
// R beat is returned to the cache as a registered one-cycle rok pulse.
module ysyx_25040111_icache_axi_rd
  import ysyx_25040111_axi_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0,
  parameter int TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rstart,
  input  logic [31:0] raddr,
  input  logic [7:0]  rlen,
  output logic        rok,
  output logic [31:0] rdata,
  output logic        rerr,
  output logic        busy,
  ysyx_25040111_icache_axi_rd_if.master axi
);

  localparam logic [ID_W-1:0] ID_VAL  = ID_W'(AXI_ID);
  localparam logic [31:0]     WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_e      state;
  logic        arvalid_r;
  logic        rready_r;
  logic [31:0] araddr_r;
  logic [7:0]  arlen_r;
  logic [7:0]  beat_cnt;
  logic [31:0] wdog;

  logic beat_ok;
  logic last_beat;
  logic wd_fire;

  assign beat_ok   = axi.rvalid && rready_r && (axi.rid == ID_VAL);
  assign last_beat = (beat_cnt == arlen_r);
  assign wd_fire   = (TIMEOUT > 0) && (state != IDLE) && (wdog == WD_LAST);

  assign busy        = (state != IDLE);
  assign axi.arvalid = arvalid_r;
  assign axi.rready  = rready_r;
  assign axi.araddr  = araddr_r;
  assign axi.arlen   = arlen_r;
  assign axi.arid    = ID_VAL;
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = (arlen_r != 8'd0) ? BURST_INCR : BURST_FIXED;

  // NOTE: all state here is non-blocking, so the watchdog assignments at the end of
  // the block override whatever the case arm scheduled in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      rok       <= 1'b0;
      rdata     <= 32'd0;
      rerr      <= 1'b0;
      araddr_r  <= 32'd0;
      arlen_r   <= 8'd0;
      beat_cnt  <= 8'd0;
      wdog      <= 32'd0;
    end else begin
      rok <= 1'b0;
      case (state)
        IDLE: begin
          if (rstart) begin
            state     <= ADDR;
            araddr_r  <= raddr;
            arlen_r   <= rlen;
            rerr      <= 1'b0;
            beat_cnt  <= 8'd0;
            wdog      <= 32'd0;
            arvalid_r <= 1'b1;
          end
        end
        ADDR: begin
          wdog <= wdog + 32'd1;
          if (arvalid_r && axi.arready) begin
            state     <= DATA;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        DATA: begin
          wdog <= wdog + 32'd1;
          if (beat_ok) begin
            rok      <= 1'b1;
            rdata    <= axi.rdata_i;
            beat_cnt <= beat_cnt + 8'd1;
            if (axi.rresp != RESP_OKAY) rerr <= 1'b1;
            // Finish on rlast or on the expected count; disagreement between them is an error.
            if (axi.rlast || last_beat) begin
              state    <= IDLE;
              rready_r <= 1'b0;
              if (axi.rlast != last_beat) rerr <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (wd_fire) begin
        state     <= IDLE;
        arvalid_r <= 1'b0;
        rready_r  <= 1'b0;
        rerr      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_icache_axi_rd.sv
// Directed bench for the icache AXI read bridge, run with a 16-cycle watchdog.
module tb_ysyx_25040111_icache_axi_rd;
  logic        clock = 1'b0;
  logic        reset;
  logic        rstart;
  logic [31:0] raddr;
  logic [7:0]  rlen;
  logic        rok;
  logic [31:0] rdata;
  logic        rerr;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  ysyx_25040111_icache_axi_rd_if #(.ID_W(4)) axi ();

  ysyx_25040111_icache_axi_rd #(
    .ID_W(4), .AXI_ID(0), .TIMEOUT(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rstart(rstart),
    .raddr (raddr),
    .rlen  (rlen),
    .rok   (rok),
    .rdata (rdata),
    .rerr  (rerr),
    .busy  (busy),
    .axi   (axi)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] addr, input logic [7:0] len);
    rstart = 1'b1;
    raddr  = addr;
    rlen   = len;
    tick();
    rstart = 1'b0;
  endtask

  task automatic ar_handshake();
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] resp,
                      input logic [3:0] id);
    axi.rvalid  = 1'b1;
    axi.rdata_i = d;
    axi.rlast   = last;
    axi.rresp   = resp;
    axi.rid     = id;
    tick();
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rresp   = 2'b00;
    axi.rid     = 4'd0;
  endtask

  initial begin
    reset = 1'b1; rstart = 1'b0; raddr = '0; rlen = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata_i = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = 4'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_arvalid", 32'(axi.arvalid), 32'd0);
    check("rst_rready",  32'(axi.rready),  32'd0);
    check("rst_rok",     32'(rok),         32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_rerr",    32'(rerr),        32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_araddr",  axi.araddr,       32'd0);
    check("rst_arlen",   32'(axi.arlen),   32'd0);

    // Single beat, arready after two cycles
    request(32'h8000_0010, 8'd0);
    check("s_arvalid", 32'(axi.arvalid), 32'd1);
    check("s_busy",    32'(busy),        32'd1);
    check("s_araddr",  axi.araddr,       32'h8000_0010);
    check("s_arlen",   32'(axi.arlen),   32'd0);
    check("s_arburst", 32'(axi.arburst), 32'd0);
    check("s_arsize",  32'(axi.arsize),  32'd2);
    check("s_arid",    32'(axi.arid),    32'd0);
    tick();
    check("s_arvalid_hold", 32'(axi.arvalid), 32'd1);
    ar_handshake();
    check("s_arvalid_drop", 32'(axi.arvalid), 32'd0);
    check("s_rready",       32'(axi.rready),  32'd1);
    check("s_rok_before",   32'(rok),         32'd0);
    beat(32'hDEAD_BEEF, 1'b1, 2'b00, 4'd0);
    check("s_rok",    32'(rok),        32'd1);
    check("s_rdata",  rdata,           32'hDEAD_BEEF);
    check("s_busy_0", 32'(busy),       32'd0);
    check("s_rerr",   32'(rerr),       32'd0);
    check("s_rready_0", 32'(axi.rready), 32'd0);
    tick();
    check("s_rok_once", 32'(rok), 32'd0);

    // Burst of 4 with gaps
    request(32'h8000_0100, 8'd3);
    check("b_arburst", 32'(axi.arburst), 32'd1);
    check("b_arlen",   32'(axi.arlen),   32'd3);
    check("b_araddr",  axi.araddr,       32'h8000_0100);
    ar_handshake();
    beat(32'h11, 1'b0, 2'b00, 4'd0);
    check("b_rok1",   32'(rok), 32'd1);
    check("b_rdata1", rdata,    32'h11);
    tick();
    check("b_gap1",   32'(rok), 32'd0);
    beat(32'h22, 1'b0, 2'b00, 4'd0);
    check("b_rdata2", rdata,    32'h22);
    tick();
    beat(32'h33, 1'b0, 2'b00, 4'd0);
    check("b_rdata3", rdata,     32'h33);
    check("b_busy3",  32'(busy), 32'd1);
    beat(32'h44, 1'b1, 2'b00, 4'd0);
    check("b_rok4",   32'(rok),  32'd1);
    check("b_rdata4", rdata,     32'h44);
    check("b_busy4",  32'(busy), 32'd0);
    check("b_rerr",   32'(rerr), 32'd0);

    // Error response on the second beat
    request(32'h8000_0200, 8'd1);
    ar_handshake();
    beat(32'hAA, 1'b0, 2'b00, 4'd0);
    check("e_rok1",  32'(rok),  32'd1);
    check("e_rerr1", 32'(rerr), 32'd0);
    beat(32'hBB, 1'b1, 2'b10, 4'd0);
    check("e_rok2",   32'(rok),  32'd1);
    check("e_rdata2", rdata,     32'hBB);
    check("e_rerr2",  32'(rerr), 32'd1);
    check("e_busy",   32'(busy), 32'd0);
    tick(); tick();
    check("e_rerr_sticky", 32'(rerr), 32'd1);

    // Early rlast, plus rstart while busy in DATA
    request(32'h8000_0300, 8'd3);
    check("l_rerr_clr", 32'(rerr), 32'd0);
    ar_handshake();
    rstart = 1'b1; raddr = 32'h9000_0000; rlen = 8'd7;
    tick();
    rstart = 1'b0;
    check("l_ign_araddr",  axi.araddr,       32'h8000_0300);
    check("l_ign_arlen",   32'(axi.arlen),   32'd3);
    check("l_ign_arvalid", 32'(axi.arvalid), 32'd0);
    beat(32'hC1, 1'b0, 2'b00, 4'd0);
    check("l_rdata1", rdata, 32'hC1);
    beat(32'hC2, 1'b1, 2'b00, 4'd0);
    check("l_rok2",   32'(rok),  32'd1);
    check("l_rdata2", rdata,     32'hC2);
    check("l_rerr",   32'(rerr), 32'd1);
    check("l_busy",   32'(busy), 32'd0);
    tick();
    check("l_no_ar",  32'(axi.arvalid), 32'd0);

    // Wrong rid beat is dropped and not counted
    request(32'h8000_0400, 8'd1);
    ar_handshake();
    beat(32'hBAD0, 1'b0, 2'b00, 4'd5);
    check("w_rok_bad", 32'(rok), 32'd0);
    beat(32'hD1, 1'b0, 2'b00, 4'd0);
    check("w_rok1",   32'(rok),  32'd1);
    check("w_rdata1", rdata,     32'hD1);
    check("w_busy1",  32'(busy), 32'd1);
    beat(32'hD2, 1'b1, 2'b00, 4'd0);
    check("w_rdata2", rdata,     32'hD2);
    check("w_busy2",  32'(busy), 32'd0);
    check("w_rerr",   32'(rerr), 32'd0);

    // Count reaches arlen without rlast
    request(32'h8000_0500, 8'd0);
    ar_handshake();
    beat(32'hE1, 1'b0, 2'b00, 4'd0);
    check("c_rok",    32'(rok),        32'd1);
    check("c_rerr",   32'(rerr),       32'd1);
    check("c_busy",   32'(busy),       32'd0);
    check("c_rready", 32'(axi.rready), 32'd0);

    // Reset while in ADDR
    request(32'h8000_0600, 8'd2);
    check("r_arvalid_pre", 32'(axi.arvalid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_arvalid", 32'(axi.arvalid), 32'd0);
    check("r_busy",    32'(busy),        32'd0);
    check("r_araddr",  axi.araddr,       32'd0);

    // Watchdog: arready never comes, abort after 16 busy cycles
    request(32'h8000_0700, 8'd0);
    for (int i = 0; i < 15; i++) tick();
    check("t_busy15", 32'(busy), 32'd1);
    check("t_rerr15", 32'(rerr), 32'd0);
    tick();
    check("t_busy16",  32'(busy),        32'd0);
    check("t_rerr16",  32'(rerr),        32'd1);
    check("t_arvalid", 32'(axi.arvalid), 32'd0);
    check("t_rok",     32'(rok),         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_25040111_icache_axi_rd.md
Name: ysyx_25040111_icache_axi_rd

Overview:
- AXI4 read-master bridge directly downstream of the instruction cache's refill port.
- Converts the cache's single-cycle rstart/raddr/rlen request into one AXI4 AR transaction and returns each R beat as a one-cycle rok pulse with rdata.
- Supports single-beat and INCR bursts, response-error capture, and an optional watchdog timeout.
- The AXI side connects to the core's memory interconnect/arbiter.

Parameters:
- ID_W, 4, width of arid/rid.
- AXI_ID, 0, constant value driven on arid; R beats with a different rid are ignored.
- TIMEOUT, 0, cycles spent in ADDR+DATA before forced abort; 0 disables the watchdog.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- rstart  in  1  request pulse from cache (one cycle)
- raddr  in  32  request start address, word aligned
- rlen  in  8  beats minus 1
- rok  out  1  one-cycle pulse per delivered beat
- rdata  out  32  beat data, valid when rok=1
- rerr  out  1  sticky error for current request
- busy  out  1  high when state != IDLE
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  32  AXI AR address
- arid  out  ID_W  = AXI_ID
- arlen  out  8  latched rlen
- arsize  out  3  constant 3'b010
- arburst  out  2  2'b01 (INCR) if latched len>0, else 2'b00
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata_i  in  32  AXI R data
- rresp  in  2  AXI R response
- rlast  in  1  AXI R last
- rid  in  ID_W  AXI R id

Behaviour:
- Reset (synchronous, active-high; clock clock): state=IDLE; arvalid=0, rready=0, rok=0, rdata=0, rerr=0, busy=0, araddr=0, arlen=0, beat counter=0, watchdog=0. Reset mid-transaction drops everything immediately; the system-level reset also covers the slave.
- FSM states:
  - IDLE -> ADDR on rstart=1. Latch raddr into araddr and rlen into arlen, clear rerr, clear beat counter. arvalid=1 from the next cycle.
  - ADDR: hold arvalid and all AR fields stable until arvalid&arready. Go to DATA on the cycle after the handshake; arvalid drops in that cycle.
  - DATA: rready=1 continuously. A beat is accepted when rvalid&rready&(rid==AXI_ID). For each accepted beat:
    - rok=1 and rdata=rdata_i on the next cycle (registered, latency 1).
    - The beat counter increments.
    - rresp!=2'b00 sets rerr.
  - DATA -> IDLE after the beat where rlast=1 or the counter reaches arlen, whichever comes first.
- Beat-count mismatches:
  - rlast before count==arlen: set rerr and return to IDLE.
  - count==arlen without rlast: set rerr, return to IDLE, and drop further beats of that burst while in IDLE (rready=0).
- rstart while busy: ignored; no state change, no latch.
- rstart in the same cycle as completion: ignored, because state is not IDLE in that cycle. The cache re-issues on the next rok cadence.
- Non-burst cache mode issues one rstart per word. Each word is a separate AR with arlen=0. The next rstart arrives at or after the rok cycle, so the bridge must be IDLE by the cycle rok is high.
- busy = (state != IDLE), combinational from state.
- Watchdog (TIMEOUT>0):
  - Counter runs in ADDR and DATA and clears on entry to ADDR.
  - When it reaches TIMEOUT: set rerr, deassert arvalid/rready, go to IDLE.
  - No rok is produced for missing beats.
- Widths: beat counter is 8 bits. arlen=255 gives 256 beats with no wrap before completion.

Decomposition:
- Shared package/header ysyx_25040111_axi_pkg:
  - AXI burst constants BURST_FIXED=2'b00, BURST_INCR=2'b01.
  - RESP_OKAY=2'b00.
  - SIZE_4B=3'b010.
  - FSM state encoding (IDLE, ADDR, DATA).
- No sub-module required. The watchdog counter is a small in-module always block.

Test Plan:
- Single beat: rstart, raddr=0x8000_0010, rlen=0, arready after 2 cycles, R beat 0xDEADBEEF with rlast=1 -> one AR with araddr=0x8000_0010, arlen=0, arburst=00; rok pulses once 1 cycle after the R handshake with rdata=0xDEADBEEF; busy low next cycle; rerr=0.
- Burst of 4: rlen=3, raddr=0x8000_0100, R beats 0x11,0x22,0x33,0x44 with rvalid gaps and rlast on the 4th -> arburst=01, arlen=3; exactly 4 rok pulses in order; return to IDLE after the 4th.
- Error response: burst rlen=1, second beat rresp=2'b10 -> both beats produce rok; rerr=1 stays set until the next rstart clears it.
- Early rlast: rlen=3, rlast on beat 2 -> 2 rok pulses, rerr=1, IDLE. Rstart while busy in DATA -> no second AR issued.
- Wrong rid: a beat with rid!=AXI_ID during DATA -> no rok and no count change; the subsequent correct beat is delivered.
- Reset and timeout: reset asserted in ADDR with arvalid=1 -> next cycle arvalid=0, busy=0. With TIMEOUT=16 and arready held low -> rerr=1 and IDLE after 16 cycles.
